// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream loader for the 64x16 unified memory with XOR checksum and cpu hold
module boot_loader #(
    parameter logic [5:0] BASE_ADDR = 6'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [5:0]  mem_address,
    output logic [15:0] mem_in,
    output logic        mem_write,
    output logic        mem_read,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HI    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]  r_state;
    logic [5:0]  r_addr;
    logic [6:0]  r_count;      // words still to be written, 1..64
    logic [7:0]  r_hi;
    logic [7:0]  r_csum;
    logic [15:0] r_mem_in;
    logic        r_mem_write;
    logic        r_cpu_hold;
    logic        r_load_done;
    logic        r_err;
    logic        w_ready;
    logic        w_accept;

    // byte_ready depends on state only so the source never sees a combinational loop through byte_valid
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE, S_HI, S_LO, S_CSUM: w_ready = 1'b1;
            default:                    w_ready = 1'b0;
        endcase
    end

    assign w_accept = byte_valid & w_ready;

    // Loader FSM: header, word assembly, one-cycle write strobe, checksum verify
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= BASE_ADDR;
            r_count     <= 7'd0;
            r_hi        <= 8'd0;
            r_csum      <= 8'd0;
            r_mem_in    <= 16'd0;
            r_mem_write <= 1'b1;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_mem_write <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cpu_hold <= 1'b1;
                        if (byte_data[7:6] != 2'b00) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            // A zero count field encodes a full 64-word image
                            r_count <= (byte_data[5:0] == 6'd0) ? 7'd64 : {1'b0, byte_data[5:0]};
                            r_csum  <= 8'd0;
                            r_addr  <= BASE_ADDR;
                            r_state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        r_hi    <= byte_data;
                        r_csum  <= r_csum ^ byte_data;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        r_mem_in    <= {r_hi, byte_data};
                        r_csum      <= r_csum ^ byte_data;
                        r_mem_write <= 1'b0;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally at 64 through the 6-bit register
                    r_addr  <= r_addr + 6'd1;
                    r_count <= r_count - 7'd1;
                    r_state <= (r_count == 7'd1) ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (byte_data == r_csum) begin
                            r_load_done <= 1'b1;
                            r_cpu_hold  <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready  = w_ready;
    assign mem_address = r_addr;
    assign mem_in      = r_mem_in;
    assign mem_write   = r_mem_write;
    assign mem_read    = 1'b1;
    assign cpu_hold    = r_cpu_hold;
    assign load_done   = r_load_done;
    assign err         = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed self-checking bench for boot_loader
`timescale 1ns/1ps
module tb_boot_loader;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        a_ready, a_mem_write, a_mem_read, a_cpu_hold, a_load_done, a_err;
    logic [5:0]  a_addr;
    logic [15:0] a_mem_in;
    logic        b_ready, b_mem_write, b_mem_read, b_cpu_hold, b_load_done, b_err;
    logic [5:0]  b_addr;
    logic [15:0] b_mem_in;

    int n_cmp;
    int n_bad;
    int cyc;
    int done_a;

    logic [5:0]  wa_a[$];
    logic [15:0] wd_a[$];
    int          wc_a[$];
    logic        wr_a[$];
    logic [5:0]  wa_b[$];

    boot_loader #(.BASE_ADDR(6'd0)) dut_a (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(a_ready), .mem_address(a_addr), .mem_in(a_mem_in),
        .mem_write(a_mem_write), .mem_read(a_mem_read), .cpu_hold(a_cpu_hold),
        .load_done(a_load_done), .err(a_err)
    );

    boot_loader #(.BASE_ADDR(6'd62)) dut_b (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(b_ready), .mem_address(b_addr), .mem_in(b_mem_in),
        .mem_write(b_mem_write), .mem_read(b_mem_read), .cpu_hold(b_cpu_hold),
        .load_done(b_load_done), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side view: record every write the memory would take at negedge
    always @(negedge clk) begin
        if (!rst) begin
            if (!a_mem_write) begin
                wa_a.push_back(a_addr);
                wd_a.push_back(a_mem_in);
                wc_a.push_back(cyc);
                wr_a.push_back(a_ready);
            end
            if (!b_mem_write) wa_b.push_back(b_addr);
            if (a_load_done) done_a = done_a + 1;
        end
    end

    task automatic clear_logs();
        wa_a.delete(); wd_a.delete(); wc_a.delete(); wr_a.delete(); wa_b.delete();
        done_a = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hold);
        int bound;
        bound = 0;
        byte_valid = 1'b1;
        byte_data = b;
        while (!a_ready && bound < 10) begin
            @(posedge clk); #1;
            bound++;
        end
        n_cmp++;
        if (!a_ready) begin
            n_bad++;
            $display("FAIL send_byte_timeout: byte_ready=%0b required 1", a_ready);
        end
        @(posedge clk); #1;
        if (!hold) byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({a_addr, a_mem_in, a_mem_write, a_mem_read, a_cpu_hold, a_load_done, a_err, a_ready}
            !== {6'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_values: addr=%0d in=%h w=%b r=%b hold=%b done=%b err=%b rdy=%b",
                     a_addr, a_mem_in, a_mem_write, a_mem_read, a_cpu_hold, a_load_done, a_err, a_ready);
        end
        n_cmp++;
        if (b_addr !== 6'd62) begin
            n_bad++;
            $display("FAIL reset_base_addr: got %0d required 62", b_addr);
        end
    endtask

    task automatic test_load_ok();
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h80, 0); send_byte(8'h01, 0);
        send_byte(8'h4C, 0); send_byte(8'h07, 0);
        send_byte(8'hCA, 0);
        n_cmp++;
        if (a_load_done !== 1'b1 || a_cpu_hold !== 1'b0) begin
            n_bad++;
            $display("FAIL load_latency: done=%b hold=%b required 1/0", a_load_done, a_cpu_hold);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (wa_a.size() !== 2) begin
            n_bad++;
            $display("FAIL ok_write_count: got %0d required 2", wa_a.size());
        end else begin
            n_cmp++;
            if (wa_a[0] !== 6'd0 || wd_a[0] !== 16'h8001) begin
                n_bad++;
                $display("FAIL ok_word0: addr=%0d data=%h required 0/8001", wa_a[0], wd_a[0]);
            end
            n_cmp++;
            if (wa_a[1] !== 6'd1 || wd_a[1] !== 16'h4C07) begin
                n_bad++;
                $display("FAIL ok_word1: addr=%0d data=%h required 1/4c07", wa_a[1], wd_a[1]);
            end
        end
        n_cmp++;
        if (done_a !== 1 || a_cpu_hold !== 1'b0 || a_err !== 1'b0 || a_load_done !== 1'b0) begin
            n_bad++;
            $display("FAIL ok_final: done_pulses=%0d hold=%b err=%b done=%b required 1/0/0/0",
                     done_a, a_cpu_hold, a_err, a_load_done);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h80, 0); send_byte(8'h01, 0);
        send_byte(8'h4C, 0); send_byte(8'h07, 0);
        send_byte(8'hCB, 0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (wa_a.size() !== 2) begin
            n_bad++;
            $display("FAIL bad_write_count: got %0d required 2", wa_a.size());
        end
        n_cmp++;
        if (a_err !== 1'b1 || a_cpu_hold !== 1'b1 || a_ready !== 1'b0 || done_a !== 0) begin
            n_bad++;
            $display("FAIL bad_csum_state: err=%b hold=%b rdy=%b done_pulses=%0d required 1/1/0/0",
                     a_err, a_cpu_hold, a_ready, done_a);
        end
    endtask

    task automatic test_bad_header();
        do_reset();
        send_byte(8'h41, 0);
        n_cmp++;
        if (a_err !== 1'b1 || a_ready !== 1'b0 || a_cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL hdr_err: err=%b rdy=%b hold=%b required 1/0/1", a_err, a_ready, a_cpu_hold);
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (wa_a.size() !== 0) begin
            n_bad++;
            $display("FAIL hdr_no_write: got %0d writes required 0", wa_a.size());
        end
        do_reset();
        n_cmp++;
        if ({a_addr, a_mem_in, a_mem_write, a_cpu_hold, a_load_done, a_err, a_ready}
            !== {6'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL hdr_rst_restore: addr=%0d in=%h w=%b hold=%b done=%b err=%b rdy=%b",
                     a_addr, a_mem_in, a_mem_write, a_cpu_hold, a_load_done, a_err, a_ready);
        end
    endtask

    task automatic test_wrap_base62();
        do_reset();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h11, 0);
        send_byte(8'h22, 0); send_byte(8'h22, 0);
        send_byte(8'h33, 0); send_byte(8'h33, 0);
        send_byte(8'h00, 0);
        n_cmp++;
        if (b_load_done !== 1'b1 || b_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_done: done=%b err=%b required 1/0", b_load_done, b_err);
        end
        n_cmp++;
        if (wa_b.size() !== 3) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d required 3", wa_b.size());
        end else begin
            n_cmp++;
            if (wa_b[0] !== 6'd62 || wa_b[1] !== 6'd63 || wa_b[2] !== 6'd0) begin
                n_bad++;
                $display("FAIL wrap_addrs: got %0d,%0d,%0d required 62,63,0", wa_b[0], wa_b[1], wa_b[2]);
            end
        end
    endtask

    task automatic test_full_64_held_valid();
        logic [7:0] cs;
        int errs_addr;
        int errs_gap;
        int errs_rdy;
        cs = 8'h00;
        errs_addr = 0; errs_gap = 0; errs_rdy = 0;
        do_reset();
        send_byte(8'h00, 1);
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i), 1);
            send_byte(8'hA0 ^ 8'(i), 1);
            cs = cs ^ 8'(i) ^ (8'hA0 ^ 8'(i));
        end
        send_byte(cs, 0);
        n_cmp++;
        if (a_load_done !== 1'b1 || a_cpu_hold !== 1'b0) begin
            n_bad++;
            $display("FAIL full_done: done=%b hold=%b required 1/0", a_load_done, a_cpu_hold);
        end
        n_cmp++;
        if (wa_a.size() !== 64) begin
            n_bad++;
            $display("FAIL full_count: got %0d required 64", wa_a.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (wa_a[i] !== 6'(i) || wd_a[i] !== {8'(i), 8'hA0 ^ 8'(i)}) errs_addr++;
                if (wr_a[i] !== 1'b0) errs_rdy++;
                if (i > 0 && (wc_a[i] - wc_a[i-1]) != 3) errs_gap++;
            end
            n_cmp++;
            if (errs_addr != 0) begin
                n_bad++;
                $display("FAIL full_addr_data: %0d wrong words required 0", errs_addr);
            end
            n_cmp++;
            if (errs_gap != 0) begin
                n_bad++;
                $display("FAIL full_spacing: %0d gaps not 3 cycles required 0", errs_gap);
            end
            n_cmp++;
            if (errs_rdy != 0) begin
                n_bad++;
                $display("FAIL full_ready_in_write: %0d write cycles with byte_ready=1 required 0", errs_rdy);
            end
        end
    endtask

    task automatic test_rst_mid_write();
        do_reset();
        send_byte(8'h04, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        n_cmp++;
        if (a_mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_in_write: mem_write=%b required 0", a_mem_write);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (a_mem_write !== 1'b1 || a_cpu_hold !== 1'b1 || a_ready !== 1'b1 || a_addr !== 6'd0 ||
            a_mem_in !== 16'd0 || a_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_values: w=%b hold=%b rdy=%b addr=%0d in=%h err=%b",
                     a_mem_write, a_cpu_hold, a_ready, a_addr, a_mem_in, a_err);
        end
        rst = 1'b0;
        clear_logs();
        send_byte(8'h02, 0);
        send_byte(8'h80, 0); send_byte(8'h01, 0);
        send_byte(8'h4C, 0); send_byte(8'h07, 0);
        send_byte(8'hCA, 0);
        n_cmp++;
        if (a_load_done !== 1'b1 || a_cpu_hold !== 1'b0 || wa_a.size() !== 2) begin
            n_bad++;
            $display("FAIL mid_reload: done=%b hold=%b writes=%0d required 1/0/2",
                     a_load_done, a_cpu_hold, wa_a.size());
        end
        // Second load after success: a new header must re-assert hold on its accept edge
        send_byte(8'h01, 0);
        n_cmp++;
        if (a_cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_hold: cpu_hold=%b required 1", a_cpu_hold);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        done_a = 0;
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        test_reset();
        test_load_ok();
        test_bad_checksum();
        test_bad_header();
        test_wrap_base62();
        test_full_64_held_valid();
        test_rst_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
